muldiv_unit: RTL and testbench

Iterative 32-bit multiply/divide unit owning the architectural HI/LO registers of the MIPS core. It sits directly downstream of the register file read ports, in parallel with the single-cycle ALU, and takes `rs`/`rt` operands for mult, multu, div and divu. It produces HI/LO for mfhi/mflo and accepts direct mthi/mtlo writes. Its `busy` output drives the pipeline stall for any instruction that reads HI/LO or issues a new mul/div while an operation is in flight.

---
 rtl/muldiv_unit.sv | 138 +++++++++++++
 tb/tb_muldiv_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit holding the architectural HI/LO pair.
// One bit per cycle: shift-add multiply (LSB-first), restoring divide (MSB-first).
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state, state_next;
  logic [1:0]  op_q;        // op[1]: divide, op[0]: signed
  logic        sign_a, sign_b;
  logic [31:0] mag_a, mag_b;
  logic [63:0] acc;         // product, or quotient in [31:0] for divide
  logic [31:0] rem;
  logic [4:0]  cnt;

  logic [32:0] mul_sum;
  logic [32:0] div_shift;   // 33-bit partial remainder after shifting in a dividend bit
  logic        div_ok;
  logic [31:0] res_hi, res_lo;

  function automatic logic [31:0] abs32(input logic signed [31:0] v);
    return v[31] ? -v : v;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return -v;
  endfunction

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return -v;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: 32 RUN cycles, then one FIX cycle
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt == 5'd31) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Single-bit step datapath for both algorithms
  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + (mag_b[cnt] ? {1'b0, mag_a} : 33'd0);
    div_shift = {rem, mag_a[5'd31 - cnt]};
    div_ok    = (div_shift >= {1'b0, mag_b});
  end

  // Sign correction and divide-by-zero handling at completion
  always_comb begin
    res_hi = acc[63:32];
    res_lo = acc[31:0];
    if (op_q[1]) begin
      res_lo = acc[31:0];
      res_hi = rem;
      // A zero divisor leaves an all-ones quotient that must not be negated
      if (op_q[0] && (sign_a ^ sign_b) && (mag_b != 32'd0)) res_lo = neg32(acc[31:0]);
      // Remainder follows the dividend; with b=0 this reproduces the original a
      if (op_q[0] && sign_a) res_hi = neg32(rem);
    end else if (op_q[0] && (sign_a ^ sign_b)) begin
      {res_hi, res_lo} = neg64(acc);
    end
  end

  // Operand capture, iteration, result write-back and direct HI/LO writes
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= 2'b00;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      mag_a  <= 32'd0;
      mag_b  <= 32'd0;
      acc    <= 64'd0;
      rem    <= 32'd0;
      cnt    <= 5'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            op_q   <= op;
            sign_a <= op[0] & a[31];
            sign_b <= op[0] & b[31];
            mag_a  <= op[0] ? abs32(a) : a;
            mag_b  <= op[0] ? abs32(b) : b;
            acc    <= 64'd0;
            rem    <= 32'd0;
            cnt    <= 5'd0;
          end
        end
        RUN: begin
          cnt <= cnt + 5'd1;
          if (op_q[1]) begin
            rem <= div_ok ? (div_shift[31:0] - mag_b) : div_shift[31:0];
            acc <= {acc[63:32], acc[30:0], div_ok};
          end else begin
            acc <= {mul_sum, acc[31:1]};
          end
        end
        FIX: begin
          hi   <= res_hi;
          lo   <= res_lo;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: cycle-level reference model with a per-cycle compare,
// plus directed vectors carrying hand-computed HI/LO results.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b0;

  // Reference model state
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;

  muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Architectural result {hi, lo} from plain arithmetic
  function automatic logic [63:0] calc(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sp;
    int sx, sy;
    sx = x;
    sy = y;
    case (o)
      2'b00: return {32'd0, x} * {32'd0, y};
      2'b01: begin
        sp = longint'(sx) * longint'(sy);
        return sp;
      end
      2'b10: begin
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        return {x % y, x / y};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        return {32'(sx % sy), 32'(sx / sy)};
      end
    endcase
  endfunction

  // Model: 33 busy cycles after acceptance, then results land with done
  always @(posedge clk) begin
    if (reset) begin
      m_left   <= 0;
      m_hi     <= 32'd0;
      m_lo     <= 32'd0;
      m_done   <= 1'b0;
      checking <= 1'b1;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi   <= p_hi;
          m_lo   <= p_lo;
          m_done <= 1'b1;
        end
      end else begin
        if (hi_we) m_hi <= wdata;
        if (lo_we) m_lo <= wdata;
        if (start) begin
          {p_hi, p_lo} <= calc(op, a, b);
          m_left <= 33;
        end
      end
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (checking) begin
      cmp("busy", {31'd0, busy}, {31'd0, (m_left != 0)});
      cmp("done", {31'd0, done}, {31'd0, m_done});
      cmp("hi", hi, m_hi);
      cmp("lo", lo, m_lo);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 60);
    if (done !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no done within %0d cycles, expected a pulse", n);
    end
  endtask

  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el);
    int n;
    tick();
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    wait_done(n);
    cmp({nm, "_latency"}, n, 32'd34);
    cmp({nm, "_hi"}, hi, eh);
    cmp({nm, "_lo"}, lo, el);
  endtask

  initial begin
    int n;
    int dones;
    reset = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    cmp("rst_busy", {31'd0, busy}, 32'd0);
    cmp("rst_hi", hi, 32'd0);
    cmp("rst_lo", lo, 32'd0);

    run_op("multu_ff", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_min", 2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run_op("div_m7_2", 2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_op("div_neg_by0", 2'b11, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF);
    run_op("divu_by0", 2'b10, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF);

    // Direct LO write while idle
    tick();
    lo_we = 1'b1; wdata = 32'hCAFEF00D;
    tick();
    lo_we = 1'b0; wdata = 32'd0;
    @(negedge clk);
    cmp("mtlo_lo", lo, 32'hCAFEF00D);
    cmp("mtlo_hi", hi, 32'h12345678);

    // Start together with mthi: write lands, then result overwrites
    tick();
    start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7; hi_we = 1'b1; wdata = 32'h11111111;
    tick();
    start = 1'b0; hi_we = 1'b0; a = $urandom; b = $urandom;
    @(negedge clk);
    cmp("start_mthi_hi", hi, 32'h11111111);
    wait_done(n);
    cmp("divu_100_7_hi", hi, 32'd2);
    cmp("divu_100_7_lo", lo, 32'd14);

    // Second start and mthi while busy are ignored
    tick();
    start = 1'b1; op = 2'b01; a = 32'hFFFFFFFD; b = 32'd7;
    tick();
    start = 1'b0;
    repeat (5) tick();
    start = 1'b1; op = 2'b10; a = 32'd1; b = 32'd1; hi_we = 1'b1; wdata = 32'hDEADBEEF;
    tick();
    start = 1'b0; hi_we = 1'b0;
    wait_done(n);
    cmp("mult_m3_7_hi", hi, 32'hFFFFFFFF);
    cmp("mult_m3_7_lo", lo, 32'hFFFFFFEB);

    // Start presented during the done cycle is accepted
    start = 1'b1; op = 2'b00; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    tick();
    start = 1'b0; a = 32'd0; b = 32'd0;
    @(negedge clk);
    cmp("done_start_busy", {31'd0, busy}, 32'd1);
    wait_done(n);
    cmp("done_start_hi", hi, 32'hFFFFFFFE);
    cmp("done_start_lo", lo, 32'h00000001);

    // Reset in the middle of a multiply aborts it with no write-back
    tick();
    start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd5;
    tick();
    start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    cmp("abort_busy", {31'd0, busy}, 32'd0);
    cmp("abort_hi", hi, 32'd0);
    cmp("abort_lo", lo, 32'd0);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    cmp("abort_no_done", dones, 32'd0);
    run_op("multu_3_4", 2'b00, 32'd3, 32'd4, 32'd0, 32'd12);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
